// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: shared types and constants for the CPU memory-mapped I/O ports
package cpu_io_pkg;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] SEROUT_ADDR = 32'h0000_FF00;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_e;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: modulo-N counter that pulses tick on the last count before wrapping
module bit_timer #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);
  localparam int W = $clog2(N) + 1;
  logic [W-1:0] r_cnt;
  assign o_tick = i_en && (r_cnt == W'(N - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_en) r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/serial_out_port.sv
// serial_out_port: serialises CPU store words as start/LSB-first data/stop frames
// with a one-entry holding buffer and a sticky overrun flag
module serial_out_port
  import cpu_io_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ovr_clr,
  output logic              busy,
  output logic              active,
  output logic              done,
  output logic              overrun,
  output logic              out
);
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  ser_state_e        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_sh, w_sh_nxt, r_hb, w_hb_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic              r_hb_v, w_hb_v_nxt, r_ovr, w_ovr_nxt, r_out, w_out_nxt;
  logic              w_tick, w_load, w_last;
  bit_timer #(.N(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .rst   (reset),
    .i_en  (r_state != IDLE),
    .o_tick(w_tick)
  );
  // a new frame starts from IDLE or directly off the final STOP cycle, so frames abut
  assign w_load = (r_hb_v || wr_en) && (r_state == IDLE || (r_state == STOP && w_tick));
  assign w_last = r_idx == IW'(DATA_W - 1);
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_idx_nxt   = r_idx;
    w_hb_nxt    = r_hb;
    w_hb_v_nxt  = r_hb_v;
    w_ovr_nxt   = (wr_en && r_hb_v) || (r_ovr && !ovr_clr);
    if (w_load) begin
      w_sh_nxt    = r_hb_v ? r_hb : wr_data;
      w_hb_v_nxt  = 1'b0;
      w_idx_nxt   = '0;
      w_state_nxt = START;
    end else begin
      if (wr_en && !r_hb_v) begin
        w_hb_nxt   = wr_data;
        w_hb_v_nxt = 1'b1;
      end
      if (w_tick)
        case (r_state)
          START: begin
            w_state_nxt = DATA;
            w_idx_nxt   = '0;
          end
          DATA: begin
            w_sh_nxt    = r_sh >> 1;
            w_idx_nxt   = w_last ? '0 : r_idx + 1'b1;
            w_state_nxt = w_last ? STOP : DATA;
          end
          STOP:    w_state_nxt = IDLE;
          default: w_state_nxt = IDLE;
        endcase
    end
    w_out_nxt = w_state_nxt == START ? 1'b0 : w_state_nxt == DATA ? w_sh_nxt[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_hb    <= '0;
      r_hb_v  <= 1'b0;
      r_idx   <= '0;
      r_ovr   <= 1'b0;
      r_out   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_hb    <= w_hb_nxt;
      r_hb_v  <= w_hb_v_nxt;
      r_idx   <= w_idx_nxt;
      r_ovr   <= w_ovr_nxt;
      r_out   <= w_out_nxt;
    end
  assign busy    = r_hb_v;
  assign active  = r_state != IDLE;
  assign done    = r_state == STOP && w_tick;
  assign overrun = r_ovr;
  assign out     = r_out;
endmodule

// File: tb/tb_serial_out_port.sv
// tb_serial_out_port: frame-level reference model checked every cycle, plus
// table-driven frame samples and directed corner-case sequences
module tb_serial_out_port;
  localparam int DW  = 32;
  localparam int CPB = 4;
  localparam int FL  = (DW + 2) * CPB;
  logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, ovr_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic busy, active, done, overrun, out;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic m_cur_v, m_pend_v, m_ovr;
  logic [DW-1:0] m_cur, m_pend;
  int m_t0;

  serial_out_port #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .ovr_clr(ovr_clr),
    .busy(busy), .active(active), .done(done), .overrun(overrun), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            off;
    logic          e_out;
    logic          e_active;
    logic          e_done;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic m_reset();
    m_cur_v = 0; m_pend_v = 0; m_ovr = 0; m_cur = '0; m_pend = '0; m_t0 = 0; cyc = 0;
  endtask

  function automatic logic m_out();
    int k;
    if (!m_cur_v) return 1'b1;
    k = (cyc - m_t0) / CPB;
    if (k == 0) return 1'b0;
    if (k <= DW) return m_cur[k-1];
    return 1'b1;
  endfunction

  // compare this cycle against the model, advance the model with this cycle's inputs, then clock
  task automatic step();
    logic e_done, set;
    e_done = m_cur_v && (cyc - m_t0 == FL - 1);
    check("out", out, m_out());
    check("busy", busy, m_pend_v);
    check("active", active, m_cur_v);
    check("done", done, e_done);
    check("overrun", overrun, m_ovr);
    set = wr_en && m_pend_v;
    if (e_done) begin
      if (m_pend_v) begin m_cur = m_pend; m_pend_v = 0; m_t0 = cyc + 1; end
      else if (wr_en) begin m_cur = wr_data; m_t0 = cyc + 1; end
      else m_cur_v = 0;
    end else if (!m_cur_v) begin
      if (wr_en) begin m_cur_v = 1; m_cur = wr_data; m_t0 = cyc + 1; end
    end else if (wr_en && !m_pend_v) begin
      m_pend = wr_data; m_pend_v = 1;
    end
    m_ovr = set || (m_ovr && !ovr_clr);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [DW-1:0] d);
    wr_en = 1; wr_data = d;
    step();
    wr_en = 0; wr_data = $urandom;
  endtask

  initial begin
    vecs[0]  = '{32'h0000_00A5,   1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{32'h0000_00A5,   4, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h0000_00A5,   5, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{32'h0000_00A5,   9, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{32'h0000_00A5,  13, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{32'h0000_00A5,  33, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{32'h0000_00A5,  37, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_00A5, 132, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000_00A5, 133, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{32'h0000_00A5, 136, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{32'h0000_00A5, 137, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{32'h8000_0000, 128, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{32'h8000_0000, 129, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{32'hFFFF_FFFF,   4, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{32'hFFFF_FFFF,   5, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{32'h0000_0100,  37, 1'b1, 1'b1, 1'b0};

    // reset held 90 ns, checked while still asserted
    #50;
    check("rst_out", out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    #40 reset = 0;
    @(posedge clk);
    #1;
    m_reset();
    idle(200);

    foreach (vecs[i]) begin
      wr(vecs[i].d);
      idle(vecs[i].off - 1);
      check($sformatf("vec%0d_out", i), out, vecs[i].e_out);
      check($sformatf("vec%0d_active", i), active, vecs[i].e_active);
      check($sformatf("vec%0d_done", i), done, vecs[i].e_done);
      idle(140 - vecs[i].off);
    end

    // back-to-back: second word waits in the buffer, second start bit abuts the first stop bit
    wr(32'hFFFF_0000);
    idle(9);
    wr(32'h1234_5678);
    check("b2b_busy_set", busy, 1'b1);
    idle(125);
    check("b2b_busy_T136", busy, 1'b1);
    check("b2b_done_T136", done, 1'b1);
    step();
    check("b2b_busy_T137", busy, 1'b0);
    check("b2b_start_T137", out, 1'b0);
    check("b2b_active_T137", active, 1'b1);
    idle(140);

    // overrun: third write dropped, clear works, set beats clear
    wr(32'hAAAA_5555);
    wr(32'h0F0F_F0F0);
    check("ovr_before", overrun, 1'b0);
    idle(1);
    wr(32'hDEAD_BEEF);
    check("ovr_set", overrun, 1'b1);
    idle(5);
    ovr_clr = 1;
    step();
    ovr_clr = 0;
    check("ovr_cleared", overrun, 1'b0);
    wr_en = 1; wr_data = 32'h5555_AAAA; ovr_clr = 1;
    step();
    wr_en = 0; ovr_clr = 0;
    check("ovr_set_wins", overrun, 1'b1);
    ovr_clr = 1;
    step();
    ovr_clr = 0;
    idle(300);

    // asynchronous reset during data bit 10 with a pending word
    wr(32'h3C3C_3C3C);
    wr(32'h0000_FFFF);
    idle(44);
    #2 reset = 1;
    #1;
    check("arst_out", out, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_active", active, 1'b0);
    check("arst_done", done, 1'b0);
    #10 reset = 0;
    @(posedge clk);
    #1;
    m_reset();
    idle(300);

    // write on the final STOP cycle with an empty buffer
    wr(32'hC3C3_0F0F);
    idle(135);
    check("wstop_done", done, 1'b1);
    check("wstop_busy", busy, 1'b0);
    wr(32'h0000_0001);
    check("wstop_start", out, 1'b0);
    check("wstop_active", active, 1'b1);
    check("wstop_busy_after", busy, 1'b0);
    idle(140);

    // randomized traffic against the model
    repeat (4000) begin
      wr_en   = $urandom_range(0, 29) == 0;
      wr_data = $urandom;
      ovr_clr = $urandom_range(0, 59) == 0;
      step();
    end
    wr_en = 0; ovr_clr = 0;
    idle(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_out_port.md
Name: serial_out_port

Overview:
- Memory-mapped output peripheral directly downstream of the multicycle CPU.
- It takes word writes from the CPU's store path and serialises each word onto the CPU's 1-bit top-level `out` pin.
- Frame format: start bit, data LSB-first, stop bit.
- A one-entry holding buffer lets the CPU issue the next store while the current frame shifts out.
- A busy/overrun handshake tells the CPU when it must stall.

Parameters:
- DATA_W, 32, width of one CPU store word and of the serial data field.
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on `out`; legal range 1..255.

Ports:
- clk      input   1       system clock, rising-edge.
- reset    input   1       asynchronous, active-high reset.
- wr_en    input   1       CPU store strobe to the port address; one-cycle pulse per word.
- wr_data  input   DATA_W  word to transmit; sampled only when wr_en=1.
- ovr_clr  input   1       clears the sticky overrun flag.
- busy     output  1       holding buffer full; CPU must not assert wr_en.
- active   output  1       a frame is currently on the line (state != IDLE).
- done     output  1       one-cycle pulse on the last cycle of each stop bit.
- overrun  output  1       sticky; set when a write is dropped.
- out      output  1       serial line; idle high.

Behaviour:
- Reset (async, active-high):
  - out=1, busy=0, active=0, done=0, overrun=0.
  - State IDLE, buffer empty, bit timer=0, bit index=0.
  - Reset asserted mid-frame aborts the frame immediately; no stop bit is emitted; pending word is discarded.
- Storage:
  - Shift register sh[DATA_W-1:0].
  - Holding buffer hb[DATA_W-1:0] with valid bit hb_v.
  - busy = hb_v.
- Write acceptance:
  - wr_en=1 with hb_v=0: word accepted.
    - If state==IDLE, load sh directly and go to START at the next edge, so out=0 one cycle after wr_en.
    - Otherwise store the word in hb and set hb_v.
  - wr_en=1 with hb_v=1: word dropped, overrun set at the next edge, state unchanged.
  - ovr_clr and an overrun event in the same cycle: the set wins.
- States:
  - IDLE: out=1. Leave on wr_en or hb_v.
  - START: out=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
  - DATA: out=sh[0] for CLKS_PER_BIT cycles per bit, then shift sh right and increment index. After index DATA_W-1 completes, go to STOP.
  - STOP: out=1 for CLKS_PER_BIT cycles.
    - done=1 during the final cycle of STOP.
    - If hb_v at that final cycle (including a write arriving that same cycle), move hb into sh, clear hb_v and go straight to START: back-to-back frames with no idle gap.
    - Otherwise go to IDLE.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - Width is clog2(CLKS_PER_BIT)+1.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles; 136 cycles at the defaults.
- out is driven from a register, so it is glitch-free.
- active = (state != IDLE).

Decomposition:
- Shared package `cpu_io_pkg`:
  - State enum {IDLE, START, DATA, STOP}.
  - Port address constant SEROUT_ADDR, used by the CPU address decoder.
  - Default DATA_W.
- One natural sub-module: `bit_timer`, a parameterised modulo-N counter with a `tick` output on wrap.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset for 90 ns, release, no writes.
  - Response: out=1, busy=0, active=0, overrun=0 for 200 cycles.
- Single frame:
  - Stimulus: wr_data=32'h0000_00A5, wr_en pulse at cycle T.
  - Response:
    - out=0 over cycles T+1..T+4.
    - Bits 1,0,1,0,0,1,0,1 then 24 zeros, each held 4 cycles.
    - out=1 over T+133..T+136, done=1 at T+136.
    - IDLE at T+137.
- Back-to-back frames:
  - Stimulus: write 32'hFFFF_0000, then write 32'h1234_5678 10 cycles later.
  - Response:
    - busy=1 from the second write until T+136.
    - Second start bit begins at T+137 with no idle gap.
    - Both frames decode correctly.
- Overrun:
  - Stimulus: three writes within 5 cycles.
  - Response:
    - Third write dropped; overrun=1 the following cycle.
    - Only two frames appear on out.
    - ovr_clr pulse returns overrun to 0.
- Reset mid-frame:
  - Stimulus: assert reset during DATA bit 10 of a frame with a pending word.
  - Response:
    - out=1 and busy=0 without waiting for a clock edge.
    - After release, no further frame is emitted.
- Write on final STOP cycle:
  - Stimulus: write 32'h0000_0001 exactly when done=1, buffer empty.
  - Response: START begins the next cycle (hb path), with no IDLE cycle.
